// File: rtl/id_eeprom_i2c_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_eeprom_i2c_ctrl
// Purpose  : I2C master for the ID EEPROM with an Avalon-MM register slave.
//            Runs a single-byte random read. Define ID_EEPROM_WRITE_EN to add
//            the TXD register and the single-byte write engine.
// Revision : 1.0 - initial release
// ============================================================================
module id_eeprom_i2c_ctrl #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_TX_BYTE = 3'd2,
    S_RX_BYTE = 3'd3,
    S_MACK    = 3'd4,
    S_RSTART  = 3'd5,
    S_STOP    = 3'd6
  } state_t;

  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [1:0]  BYTE_DEV_WR = 2'd0;
  localparam logic [1:0]  BYTE_WORD   = 2'd1;
  localparam logic [1:0]  BYTE_TXD    = 2'd2;
  localparam logic [1:0]  BYTE_DEV_RD = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        samp_q, samp_d;
  logic        op_q, op_d;
  logic [7:0]  word_q, word_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic [7:0]  rx_q, rx_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;

  logic wr_en, busy, tick, op_ok, go;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign busy         = (state_q != S_IDLE);
  assign tick         = busy && (div_q == DIV_LAST);
  assign unused_wdata = ^writedata[31:10];

`ifdef ID_EEPROM_WRITE_EN
  logic [7:0] txd_q, txd_d;

  always_comb begin
    txd_d = txd_q;
    if (wr_en && address == 2'd1) txd_d = writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) txd_q <= 8'd0;
    else          txd_q <= txd_d;
  end

  assign op_ok = 1'b1;
`else
  // Without the write engine a write command must not disturb anything.
  assign op_ok = ~writedata[9];
`endif

  assign go = wr_en && (address == 2'd0) && writedata[8] && op_ok && !busy;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    samp_d  = samp_q;
    op_d    = op_q;
    word_d  = word_q;
    done_d  = done_q;
    nack_d  = nack_q;
    rx_d    = rx_q;

    if (!busy || tick) div_d = 16'd0;
    else               div_d = div_q + 16'd1;

    if (go) begin
      state_d = S_START;
      qtr_d   = 2'd0;
      op_d    = writedata[9];
      word_d  = writedata[7:0];
      done_d  = 1'b0;
      nack_d  = 1'b0;
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      // SCL has been high for a full quarter: sample SDA.
      if (qtr_q == 2'd2) begin
        samp_d = sda_in;
        if (state_q == S_RX_BYTE) sh_d = {sh_q[6:0], sda_in};
      end
      if (qtr_q == 2'd3) begin
        case (state_q)
          S_START: begin
            state_d = S_TX_BYTE;
            bit_d   = 4'd0;
            idx_d   = BYTE_DEV_WR;
            sh_d    = {DEV_ADDR, 1'b0};
          end
          S_TX_BYTE: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end else if (samp_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              case (idx_q)
                BYTE_DEV_WR: begin
                  idx_d = BYTE_WORD;
                  bit_d = 4'd0;
                  sh_d  = word_q;
                end
                BYTE_WORD: begin
`ifdef ID_EEPROM_WRITE_EN
                  if (op_q) begin
                    idx_d = BYTE_TXD;
                    bit_d = 4'd0;
                    sh_d  = txd_q;
                  end else begin
                    state_d = S_RSTART;
                  end
`else
                  state_d = S_RSTART;
`endif
                end
                BYTE_DEV_RD: begin
                  state_d = S_RX_BYTE;
                  bit_d   = 4'd0;
                end
                default: state_d = S_STOP;
              endcase
            end
          end
          S_RSTART: begin
            state_d = S_TX_BYTE;
            bit_d   = 4'd0;
            idx_d   = BYTE_DEV_RD;
            sh_d    = {DEV_ADDR, 1'b1};
          end
          S_RX_BYTE: begin
            if (bit_q == 4'd7) state_d = S_MACK;
            else               bit_d   = bit_q + 4'd1;
          end
          S_MACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!op_q && !nack_q) rx_d = sh_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Pin enables are decoded from the next state so they switch exactly on
  // quarter boundaries and leave the block glitch-free from a flop.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      S_START: begin
        sda_oe_d = qtr_d[1];
        scl_oe_d = (qtr_d == 2'd3);
      end
      S_TX_BYTE: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = (bit_d != 4'd8) && !sh_d[7];
      end
      S_RX_BYTE, S_MACK: scl_oe_d = ~qtr_d[1];
      S_RSTART: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d == 2'd3);
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = ~qtr_d[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= 16'd0;
      qtr_q    <= 2'd0;
      bit_q    <= 4'd0;
      idx_q    <= 2'd0;
      sh_q     <= 8'd0;
      samp_q   <= 1'b0;
      op_q     <= 1'b0;
      word_q   <= 8'd0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      rx_q     <= 8'd0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      samp_q   <= samp_d;
      op_q     <= op_d;
      word_q   <= word_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      rx_q     <= rx_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {29'd0, nack_q, done_q, busy};
      2'd1:    readdata = {24'd0, rx_q};
      default: readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/id_eeprom_i2c_ctrl.md
# id_eeprom_i2c_ctrl

Hardware I2C master that sequences the ID EEPROM bus. It replaces software bit-banging of the SCL/SDA PIOs with a single-byte random-read engine (and an optional byte-write engine). Software uses it through an Avalon-MM slave with the same zero-wait, 2-bit-address register style as the PIO slaves. The block drives open-drain enables for SCL and SDA toward the board pins.

## Interface
- CLK_DIV, 125: clk cycles per quarter SCL period; legal range is 2..65535.
- DEV_ADDR, 7'h50: 7-bit EEPROM device address.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_in  in  1  SDA pin level, already synchronised externally

## Operation
- Writes occur when chipselect && !write_n.
- addr 0 write (CMD): [7:0] word address, [8] GO, [9] OP (0 = read, 1 = write). Ignored while busy. GO=1 latches the word address and OP, and clears done and nack_err.
- addr 1 write (TXD): [7:0] byte to write. Accepted at any time; the value is used only by write ops.
- addr 0 read (STATUS): [0] busy, [1] done (sticky), [2] nack_err (sticky); upper bits 0.
- addr 1 read: {24'b0, rx_byte}. addr 2 and addr 3 read 0.
- FSM states: IDLE, START, TX_BYTE, RX_BYTE, MACK, RSTART, STOP.
- Read sequence: START, TX {DEV_ADDR,0}, TX word address, RSTART, TX {DEV_ADDR,1}, RX 8 bits MSB first, master NACK (SDA released), STOP.
- Write sequence: START, TX {DEV_ADDR,0}, TX word address, TX TXD, STOP.
- TX_BYTE covers 8 data bits MSB first plus one ACK slot with SDA released. The ACK bit is sampled; 1 = NACK.
- On any NACK: set nack_err, go to STOP immediately, and leave rx_byte unchanged.
- Completion: STOP end moves to IDLE, clears busy and sets done in the same cycle. rx_byte is updated at this point only on a successful read.

## Timing
- A tick occurs every CLK_DIV clk. The divider is held at 0 in IDLE and starts counting on the GO cycle.
- Every bit-time (data, ACK, START, RSTART, STOP) is 4 ticks, q0..q3.
- Data/ACK bit: q0,q1 SCL low, with SDA changed at the q0 start. q2,q3 SCL released. sda_in is sampled at the q2→q3 boundary.
- START: q0,q1 SDA and SCL released; q2 SDA low; q3 SDA low and SCL low.
- RSTART: q0 SCL low with SDA released; q1,q2 SCL released; q3 SDA low then SCL low.
- STOP: q0 SCL low with SDA low; q1 SCL released; q2,q3 SDA released.
- busy rises 1 clk after the GO write.
- Read op: 39 bit-times = 156*CLK_DIV clk from busy rise to done.
- Write op: 29 bit-times = 116*CLK_DIV clk.
- NACK at the device-address ACK of a read: 1+9+1 = 11 bit-times total.
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, nack_err=0, rx_byte=0, TXD=0, state IDLE.
- An async reset mid-transaction releases both lines immediately. No STOP is generated.
- readdata has zero wait states and is a combinational function of address and registers.

## Configuration
- ID_EEPROM_WRITE_EN defined: OP=1 runs the write sequence, and the TXD register exists.
- ID_EEPROM_WRITE_EN undefined: TXD logic is removed. A GO with OP=1 is ignored entirely: busy stays 0, and done and nack_err are not cleared.

## Test plan
- CLK_DIV=4, slave model at 0x50 holding 0xA5 at word 0x10; write CMD 0x110 → busy for 624 clk, then STATUS=0x2 and addr 1 reads 0x000000A5.
- No slave responding (sda pulled high), CMD 0x110 → NACK after device byte, STATUS=0x6 after 176 clk, rx_byte unchanged, and the bus ends released.
- Write CMD 0x120 while busy → ignored; the in-flight transfer still completes with word 0x10.
- With ID_EEPROM_WRITE_EN: TXD=0x3C, CMD 0x310 → slave receives bytes 0xA0, 0x10, 0x3C; done after 464 clk. Without the macro, the same command leaves STATUS=0.
- reset_n low during RX_BYTE → scl_oe=0, sda_oe=0, and STATUS=0 in the same cycle.
- Reads at addr 2 and addr 3 → 0x00000000. Bus monitor reports no SDA change while SCL is high, except during START/RSTART/STOP.
